divider_restoring_n: RTL
========================

// Module: divider_restoring_n
// PURPOSE
//   Sequential unsigned restoring divider computing quotient and remainder of two nb_bit operands.
//   Drives subtractor_n every iteration: partial remainder on a_i, divisor on b_i.
//   Consumes borrow_o (quotient bit, restore decision) and diff_o (next partial remainder).
//   Sits in the datapath downstream of operand registers, one result per start/done transaction.
// PARAMETERS
//   nb_bit   8   operand, quotient and remainder width; legal range >= 2
// PORTS
//   clk_i            in   1        single clock, all state on rising edge
//   rst_i            in   1        synchronous, active-high reset
//   start_i          in   1        launch request, sampled only in IDLE
//   dividend_i       in   nb_bit   unsigned dividend, captured on accepted start
//   divisor_i        in   nb_bit   unsigned divisor, captured on accepted start
//   busy_o           out  1        high in RUN and DONE states
//   done_o           out  1        one-cycle pulse, results valid from this cycle
//   quotient_o       out  nb_bit   quotient, held until next accepted start
//   remainder_o      out  nb_bit   remainder, held until next accepted start
//   div_by_zero_o    out  1        set with done_o when divisor was 0, held with results
// BEHAVIOUR
//   - Reset: state IDLE, busy_o=0, done_o=0, quotient_o=0, remainder_o=0, div_by_zero_o=0, counter=0.
//   - FSM states: IDLE, RUN, DONE.
//     IDLE -> RUN  : start_i=1 and divisor_i!=0; capture operands, Q<=dividend_i, R<=0, cnt<=0.
//     IDLE -> DONE : start_i=1 and divisor_i==0; quotient<= all ones, remainder<=dividend_i, dbz<=1.
//     RUN  -> RUN  : cnt < nb_bit-1; one iteration per cycle, cnt<=cnt+1.
//     RUN  -> DONE : cnt == nb_bit-1 (last iteration completes this edge).
//     DONE -> IDLE : unconditional, next cycle.
//   - Iteration (subtractor width nb_bit+1): shifted = {R, Q[nb_bit-1]}; a_i=shifted, b_i={1'b0, D}.
//     borrow_o=0: R<=diff_o[nb_bit-1:0], Q<={Q[nb_bit-2:0],1'b1}.
//     borrow_o=1: R<=shifted[nb_bit-1:0], Q<={Q[nb_bit-2:0],1'b0}.
//   - Latency: start accepted at edge 0 -> done_o high during cycle nb_bit+1 (8 -> 9 cycles);
//     divide-by-zero: done_o high during cycle 1.
//   - Outputs quotient_o/remainder_o/div_by_zero_o update only on the edge entering DONE; stable otherwise.
//   - start_i while busy_o=1 is ignored, no queueing; start_i in the DONE cycle is ignored.
//   - Back-to-back: start_i accepted in the IDLE cycle immediately following DONE.
//   - Reset mid-operation: any state -> IDLE on next edge, all outputs to reset values, partial result discarded.
//   - Operands sampled once; changes on dividend_i/divisor_i during RUN have no effect.
//   - Invariant: dividend == quotient*divisor + remainder, remainder < divisor (divisor != 0).
// STRUCTURE
//   - Package div_pkg: state_t enum {IDLE, RUN, DONE}; no width constants (nb_bit is per instance).
//   - Counter width $clog2(nb_bit) bits; R, Q, D registers nb_bit bits each.
//   - One sub-module: subtractor_n #(.nb_bit(nb_bit+1)), purely combinational, no other instances.
//   - done_o and busy_o decoded from state register, no extra flops.
// TESTING (nb_bit=8 unless stated)
//   1. 13/4: start 1 cycle -> done_o at cycle 9, quotient_o=3, remainder_o=1, div_by_zero_o=0.
//   2. 255/1 and 0/7 -> q=255 r=0; q=0 r=0; busy_o high exactly cycles 1..9.
//   3. 200/0 -> done_o at cycle 1, quotient_o=8'hFF, remainder_o=200, div_by_zero_o=1.
//   4. 100/7 then start_i pulsed at cycles 3 and 9 with 50/5 -> both ignored, result q=14 r=2 held.
//   5. rst_i=1 at cycle 4 of 250/3 -> all outputs 0 next edge, no done_o; new 250/3 -> q=83 r=1.
//   6. Exhaustive nb_bit=4: all 256 pairs back-to-back -> matches a/b, a%b (divisor 0 per rule 3).

Source files
------------

// File: rtl/div_pkg.sv
// Shared types for the restoring divider. Widths stay per-instance, so only the
// controller state encoding lives here.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/subtractor_n.sv
// Combinational unsigned subtractor: diff_o = a_i - b_i, borrow_o set when b_i > a_i.
module subtractor_n #(
  parameter int nb_bit = 9
) (
  input  logic [nb_bit-1:0] a_i,
  input  logic [nb_bit-1:0] b_i,
  output logic [nb_bit-1:0] diff_o,
  output logic              borrow_o
);

  assign {borrow_o, diff_o} = {1'b0, a_i} - {1'b0, b_i};

endmodule

// File: rtl/divider_restoring_n.sv
// Sequential unsigned restoring divider: one quotient bit per clock, nb_bit
// iterations per division, divide-by-zero resolved immediately.
module divider_restoring_n
  import div_pkg::*;
#(
  parameter int nb_bit = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [nb_bit-1:0] dividend_i,
  input  logic [nb_bit-1:0] divisor_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [nb_bit-1:0] quotient_o,
  output logic [nb_bit-1:0] remainder_o,
  output logic              div_by_zero_o,
  output logic [1:0]        dbg_state
);

  // Handshake: start_i is a request honoured only in IDLE (busy_o low); once
  // accepted, busy_o stays high until the single-cycle done_o pulse, and the
  // result outputs hold their value until the next accepted start.

  localparam int CW = (nb_bit > 1) ? $clog2(nb_bit) : 1;
  localparam logic [CW-1:0] LAST = CW'(nb_bit - 1);

  state_t            state, state_nx;
  logic [CW-1:0]     cnt;
  logic [nb_bit-1:0] rem_q, quo_q, dsr_q;
  logic [nb_bit-1:0] quotient, remainder;
  logic              dbz;

  logic [nb_bit:0]   shifted, sub_b, diff;
  logic              borrow;
  logic [nb_bit-1:0] rem_nx, quo_nx;
  logic              unused_diff_msb;

  assign shifted = {rem_q, quo_q[nb_bit-1]};
  assign sub_b   = {1'b0, dsr_q};

  subtractor_n #(.nb_bit(nb_bit + 1)) u_sub (
    .a_i      (shifted),
    .b_i      (sub_b),
    .diff_o   (diff),
    .borrow_o (borrow)
  );

  // Partial remainder stays below the divisor, so a successful subtraction
  // always fits in nb_bit bits and the top difference bit is always zero.
  assign unused_diff_msb = diff[nb_bit];
  assign rem_nx = borrow ? shifted[nb_bit-1:0] : diff[nb_bit-1:0];
  assign quo_nx = {quo_q[nb_bit-2:0], ~borrow};

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start_i) state_nx = (divisor_i != '0) ? RUN : DONE;
      RUN:  if (cnt == LAST) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start_i) begin
            if (divisor_i != '0) begin
              dsr_q <= divisor_i;
              quo_q <= dividend_i;
              rem_q <= '0;
              cnt   <= '0;
            end else begin
              quotient  <= '1;
              remainder <= dividend_i;
              dbz       <= 1'b1;
            end
          end
        end
        RUN: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            quotient  <= quo_nx;
            remainder <= rem_nx;
            dbz       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o        = (state == RUN) || (state == DONE);
  assign done_o        = (state == DONE);
  assign quotient_o    = quotient;
  assign remainder_o   = remainder;
  assign div_by_zero_o = dbz;
  assign dbg_state     = state;

endmodule
